// File: rtl/iob_native2axi_pkg.sv
// Shared constants for the IOb native to AXI4 single-beat bridge:
// static AXI field values, FSM state encodings and the AXI size helper.
package iob_native2axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [2:0] PROT_DEF   = 3'b010;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] WB   = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] RR   = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  // AXI size code: log2 of bytes per beat
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/iob_axi_hs_flag.sv
// Per-channel valid/handshake tracker. Raises vld on start, holds it until
// the slave accepts, then remembers completion until the owner clears it.
// fin also covers the accepting cycle so both channels can finish together.
module iob_axi_hs_flag (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  input  logic rdy,
  output logic vld,
  output logic fin
);

  logic vld_q;
  logic done_q;
  logic hs;

  assign hs  = vld_q & rdy;
  assign vld = vld_q;
  assign fin = done_q | hs;

  // valid held until its own handshake; done is sticky until clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (start)   vld_q <= 1'b1;
      else if (hs) vld_q <= 1'b0;
      if (clr)     done_q <= 1'b0;
      else if (hs) done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/iob_native2axi.sv
// IOb native bus to AXI4 master bridge, one single-beat transaction at a time.
// Optional macro IOB_NATIVE2AXI_ERR_EN adds a sticky err flag (cleared by
// err_clr) that records any non-OKAY B or R response.
module iob_native2axi
  import iob_native2axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
`ifdef IOB_NATIVE2AXI_ERR_EN
  input  logic                  err_clr,
  output logic                  err,
`endif
  output logic [AXI_ID_W-1:0]   m_axi_awid,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [1:0]            m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [AXI_ID_W-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [1:0]            m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  logic [2:0]            state, state_nxt;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  arvalid_q, bready_q, rready_q;
  logic                  start_wr, start_rd;
  logic                  aw_fin, w_fin, wr_done;
  logic                  ar_hs, b_hs, r_hs;

  assign start_wr = (state == IDLE) & valid & (|wstrb);
  assign start_rd = (state == IDLE) & valid & ~(|wstrb);
  assign wr_done  = (state == WR) & aw_fin & w_fin;
  assign ar_hs    = arvalid_q & m_axi_arready;
  assign b_hs     = bready_q & m_axi_bvalid;
  assign r_hs     = rready_q & m_axi_rvalid;

  iob_axi_hs_flag u_aw (
    .clk  (clk),
    .rst  (rst),
    .start(start_wr),
    .clr  (wr_done),
    .rdy  (m_axi_awready),
    .vld  (m_axi_awvalid),
    .fin  (aw_fin)
  );

  iob_axi_hs_flag u_w (
    .clk  (clk),
    .rst  (rst),
    .start(start_wr),
    .clr  (wr_done),
    .rdy  (m_axi_wready),
    .vld  (m_axi_wvalid),
    .fin  (w_fin)
  );

  // next-state decode; requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_wr)      state_nxt = WR;
            else if (start_rd) state_nxt = RD;
      WR:   if (wr_done)       state_nxt = WB;
      WB:   if (b_hs)          state_nxt = RESP;
      RD:   if (ar_hs)         state_nxt = RR;
      RR:   if (r_hs)          state_nxt = RESP;
      RESP:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // request capture; wdata/wstrb only matter for writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (start_wr | start_rd) begin
      addr_q <= addr[AXI_ADDR_W-1:0];
      if (start_wr) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  // AR valid, B/R ready and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (start_rd)                 arvalid_q <= 1'b1;
      else if (ar_hs)               arvalid_q <= 1'b0;
      if (wr_done)                  bready_q  <= 1'b1;
      else if (b_hs)                bready_q  <= 1'b0;
      if ((state == RD) & ar_hs)    rready_q  <= 1'b1;
      else if (r_hs)                rready_q  <= 1'b0;
      if (r_hs)                     rdata_q   <= m_axi_rdata;
    end
  end

`ifdef IOB_NATIVE2AXI_ERR_EN
  logic err_q;
  logic err_set;
  assign err_set = (b_hs & (m_axi_bresp != RESP_OKAY)) |
                   (r_hs & (m_axi_rresp != RESP_OKAY));
  // sticky error; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_set | (err_q & ~err_clr);
  end
  assign err = err_q;
  logic unused_in;
  assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast, addr};
`else
  logic unused_in;
  assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast, addr, m_axi_bresp, m_axi_rresp};
`endif

  assign ready = (state == RESP);
  assign rdata = rdata_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = axi_size(DATA_W);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = CACHE_DEF;
  assign m_axi_awprot  = PROT_DEF;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = bready_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = axi_size(DATA_W);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = CACHE_DEF;
  assign m_axi_arprot  = PROT_DEF;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
